laser_multi: RTL and testbench

- Parametrised multi-circle coverage optimiser. Loads NPTS target points, then places NCIRC circles of radius RADIUS on a 2^COORD_W x 2^COORD_W integer grid to maximise the number of points covered by the union of the circles.
- Uses iterative coordinate descent: one full grid sweep per circle per pass. Stops early once a whole pass changes no circle position.
- Sits behind the point-stream source; results are presented to the host as flattened centre buses with a DONE level.

---
 rtl/laser_multi.sv | 257 +++++++++++++++++++++++++
 tb/tb_laser_multi.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/laser_multi.sv
// Multi-circle coverage optimiser: loads NPTS points, then places NCIRC circles by
// coordinate descent over the full grid, LANES points per cycle.
module laser_multi #(
    parameter int COORD_W = 4,
    parameter int NPTS    = 40,
    parameter int RADIUS  = 4,
    parameter int NCIRC   = 2,
    parameter int NPASS   = 3,
    parameter int LANES   = 2
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          START,
    input  logic                          IN_VALID,
    input  logic [COORD_W-1:0]            X,
    input  logic [COORD_W-1:0]            Y,
    output logic [NCIRC*COORD_W-1:0]      CX,
    output logic [NCIRC*COORD_W-1:0]      CY,
    output logic [$clog2(NPTS+1)-1:0]     BEST_CNT,
    output logic                          BUSY,
    output logic                          DONE
);

    localparam int CNT_W  = $clog2(NPTS + 1);
    localparam int NGRP   = NPTS / LANES;
    localparam int GRP_W  = (NGRP > 1) ? $clog2(NGRP) : 1;
    localparam int IDX_W  = (NPTS > 1) ? $clog2(NPTS) : 1;
    localparam int K_W    = (NCIRC > 1) ? $clog2(NCIRC) : 1;
    localparam int PASS_W = $clog2(NPASS + 1);
    localparam int D_W    = 2 * COORD_W + 1;
    localparam logic [D_W-1:0]     R2   = D_W'(RADIUS * RADIUS);
    localparam logic [COORD_W-1:0] CMAX = {COORD_W{1'b1}};

    typedef enum logic [1:0] {IDLE, LOAD, SCAN, FINISH} state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     load_cnt_q, load_cnt_d;
    logic [COORD_W-1:0]   px_q [NPTS];
    logic [COORD_W-1:0]   px_d [NPTS];
    logic [COORD_W-1:0]   py_q [NPTS];
    logic [COORD_W-1:0]   py_d [NPTS];
    logic [COORD_W-1:0]   cur_x_q [NCIRC];
    logic [COORD_W-1:0]   cur_x_d [NCIRC];
    logic [COORD_W-1:0]   cur_y_q [NCIRC];
    logic [COORD_W-1:0]   cur_y_d [NCIRC];
    logic [COORD_W-1:0]   cand_x_q, cand_x_d, cand_y_q, cand_y_d;
    logic [GRP_W-1:0]     grp_q, grp_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d, best_q, best_d;
    logic [COORD_W-1:0]   best_x_q, best_x_d, best_y_q, best_y_d;
    logic [K_W-1:0]       circ_q, circ_d;
    logic [PASS_W-1:0]    pass_q, pass_d;
    logic                 chg_q, chg_d;
    logic [NCIRC*COORD_W-1:0] cx_q, cx_d, cy_q, cy_d;
    logic [CNT_W-1:0]     best_cnt_q, best_cnt_d;

    logic [LANES-1:0]     lane_hit;
    logic [CNT_W-1:0]     lane_inc;
    logic [CNT_W-1:0]     total;
    logic                 take;
    logic [COORD_W-1:0]   nx, ny;
    logic                 swp_chg;

    // Full-width distance test; no intermediate can overflow.
    function automatic logic covered(input logic [COORD_W-1:0] ax, input logic [COORD_W-1:0] ay,
                                     input logic [COORD_W-1:0] bx, input logic [COORD_W-1:0] by);
        logic [COORD_W-1:0]   dx, dy;
        logic [2*COORD_W-1:0] sx, sy;
        logic [D_W-1:0]       sum;
        dx  = (ax >= bx) ? ax - bx : bx - ax;
        dy  = (ay >= by) ? ay - by : by - ay;
        sx  = {{COORD_W{1'b0}}, dx} * {{COORD_W{1'b0}}, dx};
        sy  = {{COORD_W{1'b0}}, dy} * {{COORD_W{1'b0}}, dy};
        sum = {1'b0, sx} + {1'b0, sy};
        return sum <= R2;
    endfunction

    always_comb begin
        logic [IDX_W-1:0] idx;
        idx      = '0;
        lane_hit = '0;
        lane_inc = '0;
        for (int l = 0; l < LANES; l++) begin
            idx = IDX_W'(int'(grp_q) * LANES + l);
            lane_hit[l] = covered(px_q[idx], py_q[idx], cand_x_q, cand_y_q);
            for (int j = 0; j < NCIRC; j++) begin
                if (K_W'(j) != circ_q && covered(px_q[idx], py_q[idx], cur_x_q[j], cur_y_q[j]))
                    lane_hit[l] = 1'b1;
            end
            lane_inc = lane_inc + CNT_W'(lane_hit[l]);
        end
    end

    always_comb begin
        state_d    = state_q;
        load_cnt_d = load_cnt_q;
        px_d       = px_q;
        py_d       = py_q;
        cur_x_d    = cur_x_q;
        cur_y_d    = cur_y_q;
        cand_x_d   = cand_x_q;
        cand_y_d   = cand_y_q;
        grp_d      = grp_q;
        cnt_d      = cnt_q;
        best_d     = best_q;
        best_x_d   = best_x_q;
        best_y_d   = best_y_q;
        circ_d     = circ_q;
        pass_d     = pass_q;
        chg_d      = chg_q;
        cx_d       = cx_q;
        cy_d       = cy_q;
        best_cnt_d = best_cnt_q;

        total   = cnt_q + lane_inc;
        take    = (total >= best_q);
        nx      = take ? cand_x_q : best_x_q;
        ny      = take ? cand_y_q : best_y_q;
        swp_chg = chg_q | (nx != cur_x_q[circ_q]) | (ny != cur_y_q[circ_q]);

        case (state_q)
            IDLE: begin
                if (START) begin
                    state_d    = LOAD;
                    load_cnt_d = '0;
                end
            end
            LOAD: begin
                if (IN_VALID) begin
                    px_d[load_cnt_q] = X;
                    py_d[load_cnt_q] = Y;
                    load_cnt_d = load_cnt_q + IDX_W'(1);
                    if (load_cnt_q == IDX_W'(NPTS - 1)) begin
                        state_d    = SCAN;
                        load_cnt_d = '0;
                        for (int k = 0; k < NCIRC; k++) begin
                            cur_x_d[k] = '0;
                            cur_y_d[k] = '0;
                        end
                        cand_x_d = '0;
                        cand_y_d = '0;
                        grp_d    = '0;
                        cnt_d    = '0;
                        best_d   = '0;
                        best_x_d = '0;
                        best_y_d = '0;
                        circ_d   = '0;
                        pass_d   = PASS_W'(1);
                        chg_d    = 1'b0;
                    end
                end
            end
            SCAN: begin
                cnt_d = total;
                grp_d = grp_q + GRP_W'(1);
                if (grp_q == GRP_W'(NGRP - 1)) begin
                    // Candidate complete: ties favour the later raster position.
                    grp_d    = '0;
                    cnt_d    = '0;
                    best_d   = take ? total : best_q;
                    best_x_d = nx;
                    best_y_d = ny;
                    cand_x_d = cand_x_q + COORD_W'(1);
                    if (cand_x_q == CMAX)
                        cand_y_d = cand_y_q + COORD_W'(1);
                    if (cand_x_q == CMAX && cand_y_q == CMAX) begin
                        cur_x_d[circ_q] = nx;
                        cur_y_d[circ_q] = ny;
                        best_d   = '0;
                        best_x_d = '0;
                        best_y_d = '0;
                        if (circ_q == K_W'(NCIRC - 1)) begin
                            circ_d = '0;
                            chg_d  = 1'b0;
                            pass_d = pass_q + PASS_W'(1);
                            if (!swp_chg || pass_q == PASS_W'(NPASS)) begin
                                state_d    = FINISH;
                                best_cnt_d = take ? total : best_q;
                                for (int k = 0; k < NCIRC; k++) begin
                                    cx_d[k*COORD_W +: COORD_W] = cur_x_d[k];
                                    cy_d[k*COORD_W +: COORD_W] = cur_y_d[k];
                                end
                            end
                        end else begin
                            circ_d = circ_q + K_W'(1);
                            chg_d  = swp_chg;
                        end
                    end
                end
            end
            FINISH: begin
                if (START) begin
                    state_d    = LOAD;
                    load_cnt_d = '0;
                    cx_d       = '0;
                    cy_d       = '0;
                    best_cnt_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            load_cnt_q <= '0;
            for (int i = 0; i < NPTS; i++) begin
                px_q[i] <= '0;
                py_q[i] <= '0;
            end
            for (int k = 0; k < NCIRC; k++) begin
                cur_x_q[k] <= '0;
                cur_y_q[k] <= '0;
            end
            cand_x_q   <= '0;
            cand_y_q   <= '0;
            grp_q      <= '0;
            cnt_q      <= '0;
            best_q     <= '0;
            best_x_q   <= '0;
            best_y_q   <= '0;
            circ_q     <= '0;
            pass_q     <= '0;
            chg_q      <= 1'b0;
            cx_q       <= '0;
            cy_q       <= '0;
            best_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            load_cnt_q <= load_cnt_d;
            px_q       <= px_d;
            py_q       <= py_d;
            cur_x_q    <= cur_x_d;
            cur_y_q    <= cur_y_d;
            cand_x_q   <= cand_x_d;
            cand_y_q   <= cand_y_d;
            grp_q      <= grp_d;
            cnt_q      <= cnt_d;
            best_q     <= best_d;
            best_x_q   <= best_x_d;
            best_y_q   <= best_y_d;
            circ_q     <= circ_d;
            pass_q     <= pass_d;
            chg_q      <= chg_d;
            cx_q       <= cx_d;
            cy_q       <= cy_d;
            best_cnt_q <= best_cnt_d;
        end
    end

    assign CX       = cx_q;
    assign CY       = cy_q;
    assign BEST_CNT = best_cnt_q;
    assign BUSY     = (state_q == LOAD) || (state_q == SCAN);
    assign DONE     = (state_q == FINISH);

endmodule

// File: tb/tb_laser_multi.sv
// Bench for laser_multi: three instances (default, single-circle, small random) run
// concurrently and are checked against a plain-loop coverage-descent model.
module tb_laser_multi;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d required %0d", nm, act, exp);
        end
    endtask

    function automatic bit in_circle(input int px, input int py, input int cx, input int cy, input int r);
        return (px - cx) * (px - cx) + (py - cy) * (py - cy) <= r * r;
    endfunction

    // Coordinate descent evaluated directly from the coverage definition.
    function automatic void model(input int cw, input int n, input int rad, input int nc, input int np,
                                  input int px[40], input int py[40],
                                  output int ex0, output int ey0, output int ex1, output int ey1,
                                  output int best, output int sweeps);
        int cx[2];
        int cy[2];
        int bx, by, bc, c;
        bit chg, cov;
        cx[0] = 0; cx[1] = 0; cy[0] = 0; cy[1] = 0;
        sweeps = 0; best = 0;
        for (int p = 1; p <= np; p++) begin
            chg = 0;
            for (int k = 0; k < nc; k++) begin
                bx = 0; by = 0; bc = 0;
                for (int y = 0; y < (1 << cw); y++) begin
                    for (int x = 0; x < (1 << cw); x++) begin
                        c = 0;
                        for (int i = 0; i < n; i++) begin
                            cov = in_circle(px[i], py[i], x, y, rad);
                            for (int j = 0; j < nc; j++)
                                if (j != k && in_circle(px[i], py[i], cx[j], cy[j], rad)) cov = 1;
                            if (cov) c++;
                        end
                        if (c >= bc) begin bc = c; bx = x; by = y; end
                    end
                end
                sweeps++;
                if (bx != cx[k] || by != cy[k]) chg = 1;
                cx[k] = bx; cy[k] = by; best = bc;
            end
            if (!chg) break;
        end
        ex0 = cx[0]; ey0 = cy[0]; ex1 = cx[1]; ey1 = cy[1];
    endfunction

    // Default instance
    logic       d_rst = 1'b1, d_start = 1'b0, d_iv = 1'b0;
    logic [3:0] d_x = '0, d_y = '0;
    logic [7:0] d_cx, d_cy, d_exp_cx = '0, d_exp_cy = '0;
    logic [5:0] d_best, d_exp_best = '0;
    logic       d_busy, d_done, d_busy_p = 1'b0, d_done_p = 1'b0;

    laser_multi u_d (
        .CLK(clk), .RST(d_rst), .START(d_start), .IN_VALID(d_iv), .X(d_x), .Y(d_y),
        .CX(d_cx), .CY(d_cy), .BEST_CNT(d_best), .BUSY(d_busy), .DONE(d_done));

    // Single circle, one lane
    logic       s_rst = 1'b1, s_start = 1'b0, s_iv = 1'b0;
    logic [3:0] s_x = '0, s_y = '0;
    logic [3:0] s_cx, s_cy, s_exp_cx = '0, s_exp_cy = '0;
    logic [5:0] s_best, s_exp_best = '0;
    logic       s_busy, s_done, s_busy_p = 1'b0, s_done_p = 1'b0;

    laser_multi #(.COORD_W(4), .NPTS(40), .RADIUS(4), .NCIRC(1), .NPASS(3), .LANES(1)) u_s (
        .CLK(clk), .RST(s_rst), .START(s_start), .IN_VALID(s_iv), .X(s_x), .Y(s_y),
        .CX(s_cx), .CY(s_cy), .BEST_CNT(s_best), .BUSY(s_busy), .DONE(s_done));

    // Small grid for randomized datasets
    logic       r_rst = 1'b1, r_start = 1'b0, r_iv = 1'b0;
    logic [2:0] r_x = '0, r_y = '0;
    logic [5:0] r_cx, r_cy, r_exp_cx = '0, r_exp_cy = '0;
    logic [3:0] r_best, r_exp_best = '0;
    logic       r_busy, r_done, r_busy_p = 1'b0, r_done_p = 1'b0;

    laser_multi #(.COORD_W(3), .NPTS(8), .RADIUS(2), .NCIRC(2), .NPASS(3), .LANES(2)) u_r (
        .CLK(clk), .RST(r_rst), .START(r_start), .IN_VALID(r_iv), .X(r_x), .Y(r_y),
        .CX(r_cx), .CY(r_cy), .BEST_CNT(r_best), .BUSY(r_busy), .DONE(r_done));

    // Per-cycle compare: held results while DONE, cleared outputs when DONE drops.
    always @(negedge clk) begin
        if (!d_rst) begin
            if (d_done) begin
                chk("d_cx", d_cx, d_exp_cx); chk("d_cy", d_cy, d_exp_cy); chk("d_best", d_best, d_exp_best);
            end
            if (d_done_p && !d_done) chk("d_clear", {d_cx, d_cy, d_best}, 0);
            if (d_busy != d_busy_p || d_done != d_done_p) chk("d_busy_done_excl", d_busy & d_done, 0);
        end
        if (!s_rst) begin
            if (s_done) begin
                chk("s_cx", s_cx, s_exp_cx); chk("s_cy", s_cy, s_exp_cy); chk("s_best", s_best, s_exp_best);
            end
            if (s_busy != s_busy_p || s_done != s_done_p) chk("s_busy_done_excl", s_busy & s_done, 0);
        end
        if (!r_rst) begin
            if (r_done) begin
                chk("r_cx", r_cx, r_exp_cx); chk("r_cy", r_cy, r_exp_cy); chk("r_best", r_best, r_exp_best);
            end
            if (r_done_p && !r_done) chk("r_clear", {r_cx, r_cy, r_best}, 0);
            if (r_busy != r_busy_p || r_done != r_done_p) chk("r_busy_done_excl", r_busy & r_done, 0);
        end
        d_busy_p = d_busy; d_done_p = d_done;
        s_busy_p = s_busy; s_done_p = s_done;
        r_busy_p = r_busy; r_done_p = r_done;
    end

    int c1x[40], c1y[40], c2x[40], c2y[40], z0x[40], z0y[40], rpx[40], rpy[40];

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic d_pulse_start();
        d_start = 1'b1; tick(); d_start = 1'b0;
    endtask

    task automatic d_load(input string nm, input int px[40], input int py[40], input bit tog);
        bit ok = 1;
        for (int i = 0; i < 40; i++) begin
            if (tog) begin
                d_iv = 1'b0; d_x = 4'd15; d_y = 4'($urandom_range(0, 15));
                tick();
                if (!d_busy) ok = 0;
            end
            d_iv = 1'b1; d_x = 4'(px[i]); d_y = 4'(py[i]);
            tick();
            if (!d_busy) ok = 0;
        end
        d_iv = 1'b0;
        chk({nm, "_busy_load"}, ok, 1);
    endtask

    task automatic d_wait(input string nm, input int exp_n, input int start_at);
        int n = 0;
        bit ok = 1;
        while (!d_done && n < exp_n + 100) begin
            d_start = (n == start_at);
            tick(); n++;
            if (!d_done && !d_busy) ok = 0;
        end
        d_start = 1'b0;
        chk({nm, "_latency"}, n, exp_n);
        chk({nm, "_busy_scan"}, ok, 1);
    endtask

    initial begin
        int a, b, c, d, e, f;
        for (int i = 0; i < 40; i++) begin
            c1x[i] = 5; c1y[i] = 5;
            c2x[i] = (i < 20) ? 2 : 13; c2y[i] = (i < 20) ? 2 : 13;
            z0x[i] = 0; z0y[i] = 0;
        end
        model(4, 40, 4, 2, 3, c1x, c1y, a, b, c, d, e, f);
        chk("model_case1", {a[7:0], b[7:0], c[7:0], d[7:0], e[7:0], f[7:0]}, {8'd5, 8'd9, 8'd15, 8'd15, 8'd40, 8'd4});
        model(4, 40, 4, 2, 3, c2x, c2y, a, b, c, d, e, f);
        chk("model_case2", {a[7:0], b[7:0], c[7:0], d[7:0], e[7:0], f[7:0]}, {8'd15, 8'd15, 8'd2, 8'd6, 8'd40, 8'd4});
        model(4, 40, 4, 1, 3, z0x, z0y, a, b, c, d, e, f);
        chk("model_single", {a[7:0], b[7:0], e[7:0], f[7:0]}, {8'd0, 8'd4, 8'd40, 8'd2});

        fork
            begin : default_inst
                repeat (3) tick();
                d_rst = 1'b0;
                chk("d_reset", {d_cx, d_cy, d_best, d_busy, d_done}, 0);
                // Case 1 with a stray START mid-scan
                d_exp_cx = {4'd15, 4'd5}; d_exp_cy = {4'd15, 4'd9}; d_exp_best = 6'd40;
                d_pulse_start();
                d_load("c1", c1x, c1y, 1'b0);
                d_wait("c1", 4 * 5120, 100);
                chk("c1_result", {d_cx, d_cy, d_best}, {8'hF5, 8'hF9, 6'd40});
                repeat (4) tick();
                // START from FINISH clears the results, then case 2
                d_pulse_start();
                chk("restart_clear", {d_done, d_busy, d_cx, d_cy, d_best}, {1'b0, 1'b1, 22'd0});
                d_exp_cx = {4'd2, 4'd15}; d_exp_cy = {4'd6, 4'd15}; d_exp_best = 6'd40;
                d_load("c2", c2x, c2y, 1'b0);
                d_wait("c2", 4 * 5120, -1);
                chk("c2_result", {d_cx, d_cy, d_best}, {8'h2F, 8'h6F, 6'd40});
                repeat (3) tick();
                // Reset in the middle of a case 2 scan
                d_pulse_start();
                d_load("c2r", c2x, c2y, 1'b0);
                repeat (2000) tick();
                chk("midscan_busy", d_busy, 1);
                d_rst = 1'b1; tick(); d_rst = 1'b0;
                chk("rst_midscan", {d_cx, d_cy, d_best, d_busy, d_done}, 0);
                tick();
                chk("rst_idle", {d_busy, d_done}, 0);
                // Reload case 1 with gapped IN_VALID and junk coordinates
                d_exp_cx = {4'd15, 4'd5}; d_exp_cy = {4'd15, 4'd9}; d_exp_best = 6'd40;
                d_pulse_start();
                d_load("c1g", c1x, c1y, 1'b1);
                d_wait("c1g", 4 * 5120, -1);
                chk("c1g_result", {d_cx, d_cy, d_best}, {8'hF5, 8'hF9, 6'd40});
                repeat (3) tick();
            end
            begin : single_inst
                bit ok = 1;
                int n = 0;
                repeat (3) tick();
                s_rst = 1'b0;
                chk("s_reset", {s_cx, s_cy, s_best, s_busy, s_done}, 0);
                s_exp_cx = 4'd0; s_exp_cy = 4'd4; s_exp_best = 6'd40;
                s_start = 1'b1; tick(); s_start = 1'b0;
                for (int i = 0; i < 40; i++) begin
                    s_iv = 1'b1; s_x = 4'(z0x[i]); s_y = 4'(z0y[i]);
                    tick();
                end
                s_iv = 1'b0;
                while (!s_done && n < 2 * 256 * 40 + 100) begin
                    tick(); n++;
                    if (!s_done && !s_busy) ok = 0;
                end
                chk("s_latency", n, 2 * 256 * 40);
                chk("s_busy_scan", ok, 1);
                chk("s_result", {s_cx, s_cy, s_best}, {4'd0, 4'd4, 6'd40});
                repeat (3) tick();
            end
            begin : random_inst
                int ex0, ey0, ex1, ey1, eb, sw, n;
                bit ok;
                repeat (3) tick();
                r_rst = 1'b0;
                chk("r_reset", {r_cx, r_cy, r_best, r_busy, r_done}, 0);
                for (int t = 0; t < 8; t++) begin
                    for (int i = 0; i < 40; i++) begin
                        rpx[i] = (i < 8) ? int'($urandom_range(0, 7)) : 0;
                        rpy[i] = (i < 8) ? int'($urandom_range(0, 7)) : 0;
                    end
                    model(3, 8, 2, 2, 3, rpx, rpy, ex0, ey0, ex1, ey1, eb, sw);
                    r_start = 1'b1; tick(); r_start = 1'b0;
                    chk("r_start_clear", {r_done, r_busy, r_cx, r_cy, r_best}, {1'b0, 1'b1, 16'd0});
                    r_exp_cx = {3'(ex1), 3'(ex0)}; r_exp_cy = {3'(ey1), 3'(ey0)}; r_exp_best = 4'(eb);
                    for (int i = 0; i < 8; i++) begin
                        if ($urandom_range(0, 1) == 1) begin
                            r_iv = 1'b0; r_x = 3'($urandom_range(0, 7)); r_y = 3'($urandom_range(0, 7));
                            tick();
                        end
                        r_iv = 1'b1; r_x = 3'(rpx[i]); r_y = 3'(rpy[i]);
                        tick();
                    end
                    r_iv = 1'b0;
                    n = 0; ok = 1;
                    while (!r_done && n < sw * 256 + 100) begin
                        r_start = ($urandom_range(0, 63) == 0);
                        tick(); n++;
                        if (!r_done && !r_busy) ok = 0;
                    end
                    r_start = 1'b0;
                    chk("r_latency", n, sw * 256);
                    chk("r_busy_scan", ok, 1);
                    chk("r_result", {r_cx, r_cy, r_best}, {r_exp_cx, r_exp_cy, r_exp_best});
                    repeat (2) tick();
                end
            end
        join

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
